tf_power_gen: RTL and testbench

Sequential twiddle-factor generator for the radix-16 NWC butterfly datapath. Given a group root omega and a modulus, it computes the sixteen powers omega^0 … omega^15 mod modulus with one modular multiplier, one power per cycle. It presents all sixteen as a parallel bundle, together with the modulus, under a valid/ready handshake. Its TF0_out…TF15_out and modulus_out drive the 16-lane twiddle-factor delay buffer, which then aligns them with the butterfly pipeline.

---
 rtl/tf_power_gen_if.sv | 52 +++++
 rtl/tf_power_gen.sv | 121 ++++++++++++
 tb/tb_tf_power_gen.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tf_power_gen_if.sv
// tf_power_gen_if
//   Handshake/data bundle between a requester and the twiddle-factor power
//   generator.
//   master: drives start, omega_in, modulus_in, tf_ready;
//           observes start_ready, tf_valid, TF0_out..TF15_out, modulus_out, busy.
//   slave : the generator side (directions reversed).
`ifndef D_width
`define D_width 32
`endif

interface tf_power_gen_if #(
  parameter int unsigned DW = `D_width
);
  logic          start;
  logic          start_ready;
  logic [DW-1:0] omega_in;
  logic [DW-1:0] modulus_in;
  logic          tf_valid;
  logic          tf_ready;
  logic [DW-1:0] TF0_out;
  logic [DW-1:0] TF1_out;
  logic [DW-1:0] TF2_out;
  logic [DW-1:0] TF3_out;
  logic [DW-1:0] TF4_out;
  logic [DW-1:0] TF5_out;
  logic [DW-1:0] TF6_out;
  logic [DW-1:0] TF7_out;
  logic [DW-1:0] TF8_out;
  logic [DW-1:0] TF9_out;
  logic [DW-1:0] TF10_out;
  logic [DW-1:0] TF11_out;
  logic [DW-1:0] TF12_out;
  logic [DW-1:0] TF13_out;
  logic [DW-1:0] TF14_out;
  logic [DW-1:0] TF15_out;
  logic [DW-1:0] modulus_out;
  logic          busy;

  modport master (
    output start, omega_in, modulus_in, tf_ready,
    input  start_ready, tf_valid, modulus_out, busy,
    input  TF0_out, TF1_out, TF2_out, TF3_out, TF4_out, TF5_out, TF6_out, TF7_out,
    input  TF8_out, TF9_out, TF10_out, TF11_out, TF12_out, TF13_out, TF14_out, TF15_out
  );

  modport slave (
    input  start, omega_in, modulus_in, tf_ready,
    output start_ready, tf_valid, modulus_out, busy,
    output TF0_out, TF1_out, TF2_out, TF3_out, TF4_out, TF5_out, TF6_out, TF7_out,
    output TF8_out, TF9_out, TF10_out, TF11_out, TF12_out, TF13_out, TF14_out, TF15_out
  );
endinterface

// File: rtl/tf_power_gen.sv
// tf_power_gen
//   Sequential twiddle-factor generator: computes omega^0..omega^15 mod modulus
//   with a single modular multiplier, one power per cycle, and presents the
//   sixteen powers plus the modulus as a parallel bundle under valid/ready.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset
//     bus  - tf_power_gen_if.slave: start/start_ready request handshake,
//            omega_in/modulus_in operands, tf_valid/tf_ready result handshake,
//            TF0_out..TF15_out powers, modulus_out, busy.
`ifndef D_width
`define D_width 32
`endif

module tf_power_gen #(
  parameter int unsigned DW = `D_width
) (
  input  logic          clk,
  input  logic          rst,
  tf_power_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [DW-1:0] omega_q;
  logic [DW-1:0] mod_q;
  logic [DW-1:0] tf_q [16];
  logic          start_ready_q;
  logic          tf_valid_q;
  logic          busy_q;

  logic [2*DW-1:0] prod;
  logic [DW-1:0]   tf_d;

  // Full-width product, reduced in one combinational remainder; the
  // remainder is always below mod_q so the narrowing cast loses nothing.
  always_comb begin
    prod = {{DW{1'b0}}, tf_q[cnt_q - 4'd1]} * {{DW{1'b0}}, omega_q};
    tf_d = DW'(prod % {{DW{1'b0}}, mod_q});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      omega_q       <= '0;
      mod_q         <= '0;
      start_ready_q <= 1'b1;
      tf_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        tf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            omega_q       <= bus.omega_in;
            mod_q         <= bus.modulus_in;
            tf_q[0]       <= {{(DW-1){1'b0}}, 1'b1};
            cnt_q         <= 4'd1;
            state_q       <= CALC;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        CALC: begin
          tf_q[cnt_q] <= tf_d;
          cnt_q       <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q    <= DONE;
            tf_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.tf_ready) begin
            state_q       <= IDLE;
            tf_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= IDLE;
          tf_valid_q    <= 1'b0;
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.tf_valid    = tf_valid_q;
  assign bus.busy        = busy_q;
  assign bus.modulus_out = mod_q;

  assign bus.TF0_out  = tf_q[0];
  assign bus.TF1_out  = tf_q[1];
  assign bus.TF2_out  = tf_q[2];
  assign bus.TF3_out  = tf_q[3];
  assign bus.TF4_out  = tf_q[4];
  assign bus.TF5_out  = tf_q[5];
  assign bus.TF6_out  = tf_q[6];
  assign bus.TF7_out  = tf_q[7];
  assign bus.TF8_out  = tf_q[8];
  assign bus.TF9_out  = tf_q[9];
  assign bus.TF10_out = tf_q[10];
  assign bus.TF11_out = tf_q[11];
  assign bus.TF12_out = tf_q[12];
  assign bus.TF13_out = tf_q[13];
  assign bus.TF14_out = tf_q[14];
  assign bus.TF15_out = tf_q[15];

endmodule

// File: tb/tb_tf_power_gen.sv
// tb_tf_power_gen
//   Self-checking bench for tf_power_gen: table of operand/expected-bundle
//   records, a scoreboard queue of expected bundles, plus hand-written
//   sequences for backpressure, mid-run reset and back-to-back runs.
`ifndef D_width
`define D_width 32
`endif

module tb_tf_power_gen;
  localparam int unsigned DW = `D_width;

  typedef struct packed {
    logic [DW-1:0]        omega;
    logic [DW-1:0]        modulus;
    logic [15:0][DW-1:0]  exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  vec_t sb [$];
  vec_t tbl [6];
  logic [15:0][DW-1:0] tf_act;

  tf_power_gen_if #(.DW(DW)) bus ();

  tf_power_gen #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always_comb begin
    tf_act = {bus.TF15_out, bus.TF14_out, bus.TF13_out, bus.TF12_out,
              bus.TF11_out, bus.TF10_out, bus.TF9_out,  bus.TF8_out,
              bus.TF7_out,  bus.TF6_out,  bus.TF5_out,  bus.TF4_out,
              bus.TF3_out,  bus.TF2_out,  bus.TF1_out,  bus.TF0_out};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t from_list(input logic [DW-1:0] om, input logic [DW-1:0] md,
                                     input int l [16]);
    vec_t v;
    v.omega   = om;
    v.modulus = md;
    for (int k = 0; k < 16; k++) v.exp[k] = DW'(l[k]);
    return v;
  endfunction

  // Reference powers by repeated multiplication of the reduced root.
  function automatic vec_t model(input logic [DW-1:0] om, input logic [DW-1:0] md);
    vec_t v;
    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] r;
    v.omega   = om;
    v.modulus = md;
    r   = {{DW{1'b0}}, om} % {{DW{1'b0}}, md};
    acc = 1;
    for (int k = 0; k < 16; k++) begin
      v.exp[k] = acc[DW-1:0];
      acc = (acc * r) % {{DW{1'b0}}, md};
    end
    return v;
  endfunction

  task automatic check_bundle(input vec_t e, input string tag);
    for (int k = 0; k < 16; k++) chk($sformatf("%s_TF%0d", tag, k), tf_act[k], e.exp[k]);
    chk({tag, "_modulus_out"}, bus.modulus_out, e.modulus);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.tf_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic pop_expected(output vec_t e);
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: got 0 entries, required 1");
      e = '0;
    end else begin
      e = sb.pop_front();
    end
  endtask

  // One full transaction; hold > 0 keeps tf_ready low for that many cycles
  // after tf_valid while pulsing start with other operands.
  task automatic do_run(input vec_t v, input int hold, input string tag);
    int   lat;
    vec_t e;
    chk({tag, "_start_ready_idle"}, DW'(bus.start_ready), 1);
    bus.tf_ready   = (hold == 0);
    bus.omega_in   = v.omega;
    bus.modulus_in = v.modulus;
    bus.start      = 1'b1;
    sb.push_back(v);
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy_calc"}, DW'(bus.busy), 1);
    chk({tag, "_start_ready_calc"}, DW'(bus.start_ready), 0);
    wait_valid(lat);
    chk({tag, "_latency"}, DW'(lat), 15);
    pop_expected(e);
    check_bundle(e, tag);
    for (int i = 0; i < hold; i++) begin
      bus.start      = i[0];
      bus.omega_in   = v.omega + 5;
      bus.modulus_in = v.modulus + 3;
      tick();
      chk({tag, "_hold_valid"}, DW'(bus.tf_valid), 1);
      chk({tag, "_hold_start_ready"}, DW'(bus.start_ready), 0);
      chk({tag, "_hold_busy"}, DW'(bus.busy), 1);
      chk({tag, "_hold_tf"}, DW'(tf_act == e.exp), 1);
      chk({tag, "_hold_mod"}, bus.modulus_out, e.modulus);
    end
    bus.start    = 1'b0;
    bus.tf_ready = 1'b1;
    tick();
    chk({tag, "_post_valid"}, DW'(bus.tf_valid), 0);
    chk({tag, "_post_start_ready"}, DW'(bus.start_ready), 1);
    chk({tag, "_post_busy"}, DW'(bus.busy), 0);
    chk({tag, "_post_tf"}, DW'(tf_act == e.exp), 1);
    chk({tag, "_post_mod"}, bus.modulus_out, e.modulus);
  endtask

  initial begin
    int basic [16] = '{1, 3, 9, 10, 13, 5, 15, 11, 16, 14, 8, 7, 4, 12, 2, 6};
    int pow2  [16] = '{1, 2, 4, 8, 16, 15, 13, 9, 1, 2, 4, 8, 16, 15, 13, 9};
    logic [DW-1:0] mx;
    logic [DW-1:0] rm;
    logic [DW-1:0] ro;
    vec_t wide;
    vec_t e;
    int   t1;
    int   t2;
    int   lat;

    checks = 0;
    errors = 0;
    cyc    = 0;
    bus.start      = 1'b0;
    bus.tf_ready   = 1'b1;
    bus.omega_in   = '0;
    bus.modulus_in = '0;
    rst = 1'b1;

    mx = '1;
    wide.omega   = mx - 1;
    wide.modulus = mx;
    for (int k = 0; k < 16; k++) wide.exp[k] = k[0] ? mx - 1 : DW'(1);

    tbl[0] = from_list(DW'(3), DW'(17), basic);
    tbl[1] = from_list(DW'(20), DW'(17), basic);
    tbl[2] = wide;
    tbl[3] = from_list(DW'(2), DW'(17), pow2);
    rm = DW'($urandom); if (rm < 2) rm = 2;
    ro = DW'($urandom);
    tbl[4] = model(ro, rm);
    rm = DW'($urandom_range(1000, 2)); ro = DW'($urandom);
    tbl[5] = model(ro, rm);

    #1;
    chk("reset_tf", DW'(tf_act == '0), 1);
    chk("reset_modulus_out", bus.modulus_out, 0);
    chk("reset_tf_valid", DW'(bus.tf_valid), 0);
    chk("reset_busy", DW'(bus.busy), 0);
    chk("reset_start_ready", DW'(bus.start_ready), 1);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) do_run(tbl[i], 0, $sformatf("vec%0d", i));

    // Backpressure with ignored start pulses.
    do_run(tbl[0], 10, "bp");

    // Asynchronous reset mid-CALC (cnt=7), partial run discarded.
    bus.omega_in   = DW'(3);
    bus.modulus_in = DW'(17);
    bus.start      = 1'b1;
    sb.push_back(tbl[0]);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("rst_mid_tf", DW'(tf_act == '0), 1);
    chk("rst_mid_modulus_out", bus.modulus_out, 0);
    chk("rst_mid_tf_valid", DW'(bus.tf_valid), 0);
    chk("rst_mid_busy", DW'(bus.busy), 0);
    chk("rst_mid_start_ready", DW'(bus.start_ready), 1);
    #1;
    rst = 1'b0;
    tick();
    do_run(tbl[3], 0, "after_rst");

    // Back-to-back with tf_ready tied high and start held high.
    bus.tf_ready   = 1'b1;
    bus.omega_in   = DW'(3);
    bus.modulus_in = DW'(17);
    bus.start      = 1'b1;
    sb.push_back(tbl[0]);
    tick();
    bus.omega_in   = wide.omega;
    bus.modulus_in = wide.modulus;
    wait_valid(lat);
    chk("b2b_latency1", DW'(lat), 15);
    t1 = cyc;
    pop_expected(e);
    check_bundle(e, "b2b_first");
    sb.push_back(wide);
    tick();
    chk("b2b_e16_valid", DW'(bus.tf_valid), 0);
    chk("b2b_e16_start_ready", DW'(bus.start_ready), 1);
    chk("b2b_e16_mod", bus.modulus_out, DW'(17));
    tick();
    chk("b2b_e17_busy", DW'(bus.busy), 1);
    chk("b2b_e17_start_ready", DW'(bus.start_ready), 0);
    chk("b2b_e17_mod", bus.modulus_out, wide.modulus);
    bus.start = 1'b0;
    wait_valid(lat);
    t2 = cyc;
    chk("b2b_spacing", DW'(t2 - t1), 17);
    pop_expected(e);
    check_bundle(e, "b2b_second");
    tick();
    chk("b2b_end_valid", DW'(bus.tf_valid), 0);
    chk("b2b_end_start_ready", DW'(bus.start_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
